// File: rtl/fifo_bank_merge_sync.sv
// fifo_bank_merge_sync: bank of NUM_CH independent synchronous FIFOs sitting
// between two merge stages. Each channel stores the add-stage payload of
// valid upstream words, and keeps an occupancy count, a sticky overflow flag
// and a registered write-ready with a reserve margin. A synchronous flush
// clears every channel.
// Build option: define FIFO_BANK_MERGE_FWFT_EN for first-word-fall-through
// read data. Without it, read data is registered one cycle after the pop.
`ifndef DATA_WIDTH_BUFF_SO_SEG
`define DATA_WIDTH_BUFF_SO_SEG 16
`endif
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 8
`endif
`ifndef NUM_SEG_PER_STG
`define NUM_SEG_PER_STG 4
`endif
`ifndef BITS_SLOW_BLK_BUFF_ADDR
`define BITS_SLOW_BLK_BUFF_ADDR 3
`endif
`ifndef MODE_WORK
`define MODE_WORK 1'b1
`endif

module fifo_bank_merge_sync #(
  parameter int DATA_WIDTH         = `DATA_WIDTH_BUFF_SO_SEG,
  parameter int DATA_WIDTH_ADD_STG = `DATA_WIDTH_ADD_STG,
  parameter int NUM_CH             = `NUM_SEG_PER_STG,
  parameter int BITS_ADDR          = `BITS_SLOW_BLK_BUFF_ADDR,
  parameter int READY_MARGIN       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_b,
  input  logic                                 unit_en,
  input  logic                                 mode,
  input  logic                                 flush,
  input  logic                                 next_stg_rd_en,
  input  logic [NUM_CH-1:0]                    blk_en_adv,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         data_in_blk,
  input  logic [NUM_CH-1:0]                    en_intake,
  output logic [NUM_CH*DATA_WIDTH_ADD_STG-1:0] data_out,
  output logic [NUM_CH-1:0]                    data_out_valid,
  output logic [NUM_CH-1:0]                    fifo_empty,
  output logic [NUM_CH-1:0]                    wr_ready_adv,
  output logic [NUM_CH-1:0]                    wr_ready,
  output logic [NUM_CH*(BITS_ADDR+1)-1:0]      occupancy,
  output logic [NUM_CH-1:0]                    overflow
);

  localparam int DEPTH = 1 << BITS_ADDR;
  localparam int PW    = BITS_ADDR + 1;
  localparam int DWA   = DATA_WIDTH_ADD_STG;
  localparam logic [PW-1:0] READY_LIMIT = PW'(DEPTH - 1 - READY_MARGIN);

  logic mode_work;
  assign mode_work = (mode == `MODE_WORK);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DWA-1:0] din;
    logic [DWA-1:0] mem_q [DEPTH];
    logic [DWA-1:0] head;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
    logic [DWA-1:0] dout_q, dout_d;
    logic           ovf_q, ovf_d, rdy_q, rdy_adv;
    logic           full, empty, wreq, rd, wr;

    assign din   = data_in_blk[i*DATA_WIDTH + DATA_WIDTH - 1 -: DWA];
    assign head  = mem_q[rd_ptr_q[BITS_ADDR-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[BITS_ADDR] != rd_ptr_q[BITS_ADDR]) &&
                   (wr_ptr_q[BITS_ADDR-1:0] == rd_ptr_q[BITS_ADDR-1:0]);
    assign wreq  = mode_work & unit_en & blk_en_adv[i] & din[0];
    assign rd    = next_stg_rd_en & en_intake[i] & ~empty;
    // A full channel still takes a write when the head is popped that cycle.
    assign wr    = wreq & (~full | rd);
    assign rdy_adv = mode_work & (occ_q <= READY_LIMIT);

    if (DATA_WIDTH > DWA) begin : g_low
      logic unused_low;
      assign unused_low = ^data_in_blk[i*DATA_WIDTH +: DATA_WIDTH - DWA];
    end

    // Next-state for pointers, occupancy, overflow and read data register.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      dout_d   = dout_q;
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        occ_d    = '0;
        ovf_d    = 1'b0;
      end else begin
        if (wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          dout_d   = head;
        end
        if (wr && !rd) occ_d = occ_q + PW'(1);
        else if (rd && !wr) occ_d = occ_q - PW'(1);
        if (wreq && full && !rd) ovf_d = 1'b1;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        ovf_q    <= 1'b0;
        dout_q   <= '0;
        rdy_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
        ovf_q    <= ovf_d;
        dout_q   <= dout_d;
        rdy_q    <= rdy_adv;
      end
    end

    // Storage array; contents are meaningless once pointers are cleared.
    always_ff @(posedge clk) begin
      if (wr && !flush) mem_q[wr_ptr_q[BITS_ADDR-1:0]] <= din;
    end

`ifdef FIFO_BANK_MERGE_FWFT_EN
    // Head is shown directly; when empty, the last popped word is held.
    assign data_out[i*DWA +: DWA] = empty ? dout_q : head;
    assign data_out_valid[i]      = ~empty;
`else
    logic dv_q, dv_d;

    // Valid pulses for the cycle following a pop; flush kills it.
    always_comb begin
      dv_d = rd & ~flush;
    end

    // Read-valid register.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) dv_q <= 1'b0;
      else        dv_q <= dv_d;
    end

    assign data_out[i*DWA +: DWA] = dout_q;
    assign data_out_valid[i]      = dv_q;
`endif

    assign fifo_empty[i]            = empty;
    assign wr_ready_adv[i]          = rdy_adv;
    assign wr_ready[i]              = rdy_q;
    assign occupancy[i*PW +: PW]    = occ_q;
    assign overflow[i]              = ovf_q;
  end

endmodule

// File: tb/tb_fifo_bank_merge_sync.sv
// Directed self-checking bench for fifo_bank_merge_sync (DEPTH=8, margin 2).
module tb_fifo_bank_merge_sync;
  localparam int DW = 16;
  localparam int DWA = 8;
  localparam int NCH = 4;
  localparam int BA = 3;

  logic clk = 1'b0;
  logic rst_b, unit_en, mode, flush, next_stg_rd_en;
  logic [NCH-1:0] blk_en_adv, en_intake;
  logic [NCH*DW-1:0] data_in_blk;
  logic [NCH*DWA-1:0] data_out;
  logic [NCH-1:0] data_out_valid, fifo_empty, wr_ready_adv, wr_ready, overflow;
  logic [NCH*(BA+1)-1:0] occupancy;

  int vectors = 0;
  int errors = 0;

  fifo_bank_merge_sync #(
    .DATA_WIDTH(DW), .DATA_WIDTH_ADD_STG(DWA), .NUM_CH(NCH),
    .BITS_ADDR(BA), .READY_MARGIN(2)
  ) dut (
    .clk(clk), .rst_b(rst_b), .unit_en(unit_en), .mode(mode), .flush(flush),
    .next_stg_rd_en(next_stg_rd_en), .blk_en_adv(blk_en_adv),
    .data_in_blk(data_in_blk), .en_intake(en_intake), .data_out(data_out),
    .data_out_valid(data_out_valid), .fifo_empty(fifo_empty),
    .wr_ready_adv(wr_ready_adv), .wr_ready(wr_ready),
    .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [7:0] p);
    data_in_blk[ch*DW +: DW] = {p, 8'h3C};
  endtask

  function automatic logic [31:0] occ(input int ch);
    return 32'(occupancy[ch*(BA+1) +: (BA+1)]);
  endfunction

  function automatic logic [31:0] dout(input int ch);
    return 32'(data_out[ch*DWA +: DWA]);
  endfunction

  task automatic read_one(input int ch, input logic [7:0] w, input string tag);
`ifdef FIFO_BANK_MERGE_FWFT_EN
    check_eq({tag, "_head"}, dout(ch), 32'(w));
    check_eq({tag, "_vld"}, 32'(data_out_valid[ch]), 1);
`endif
    next_stg_rd_en = 1'b1;
    en_intake[ch] = 1'b1;
    tick();
    en_intake[ch] = 1'b0;
    next_stg_rd_en = 1'b0;
`ifndef FIFO_BANK_MERGE_FWFT_EN
    check_eq({tag, "_dout"}, dout(ch), 32'(w));
    check_eq({tag, "_vld"}, 32'(data_out_valid[ch]), 1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w3 [3];
    w3[0] = 8'hA1; w3[1] = 8'hB3; w3[2] = 8'hC5;
    rst_b = 1'b0; unit_en = 1'b1; mode = `MODE_WORK; flush = 1'b0;
    next_stg_rd_en = 1'b0; blk_en_adv = '0; en_intake = '0; data_in_blk = '0;
    #2;
    check_eq("rst_occ", 32'(occupancy), 0);
    check_eq("rst_empty", 32'(fifo_empty), 32'hF);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_dv", 32'(data_out_valid), 0);
    check_eq("rst_rdy", 32'(wr_ready), 0);
    check_eq("rst_dout", 32'(data_out), 0);
    tick(); tick();
    rst_b = 1'b1;
    tick();
    check_eq("rdy_adv_idle", 32'(wr_ready_adv), 32'hF);
    check_eq("rdy_idle", 32'(wr_ready), 32'hF);

    // Three writes then three reads on ch0
    for (int k = 0; k < 3; k++) begin
      set_word(0, w3[k]); blk_en_adv = 4'b0001;
      tick();
      check_eq("wr_occ0", occ(0), 32'(k + 1));
    end
    blk_en_adv = '0;
    check_eq("ne_empty0", 32'(fifo_empty[0]), 0);
    for (int k = 0; k < 3; k++) begin
      read_one(0, w3[k], "rd0");
      check_eq("rd_occ0", occ(0), 32'(2 - k));
    end
    check_eq("empty0", 32'(fifo_empty[0]), 1);
    next_stg_rd_en = 1'b1; en_intake = 4'b0001;
    tick();
    next_stg_rd_en = 1'b0; en_intake = '0;
    check_eq("emptyrd_vld", 32'(data_out_valid[0]), 0);
    check_eq("emptyrd_occ", occ(0), 0);
    check_eq("emptyrd_hold", dout(0), 32'hC5);

    // Filtered writes: invalid bit, wrong mode, unit disabled
    set_word(0, 8'hA0); blk_en_adv = 4'b0001;
    tick();
    check_eq("inv_occ", occ(0), 0);
    set_word(0, 8'hA1); mode = ~`MODE_WORK;
    tick();
    check_eq("mode_occ", occ(0), 0);
    check_eq("mode_rdy_adv", 32'(wr_ready_adv), 0);
    check_eq("mode_rdy", 32'(wr_ready), 0);
    mode = `MODE_WORK; unit_en = 1'b0;
    tick();
    check_eq("uen_occ", occ(0), 0);
    check_eq("uen_empty", 32'(fifo_empty[0]), 1);
    unit_en = 1'b1; blk_en_adv = '0;

    // Fill ch1, watch ready margin
    for (int k = 0; k < 8; k++) begin
      set_word(1, 8'(8'h11 + 2 * k)); blk_en_adv = 4'b0010;
      tick();
      check_eq("fill_occ1", occ(1), 32'(k + 1));
      check_eq("fill_adv1", 32'(wr_ready_adv[1]), 32'((k + 1) <= 5));
      check_eq("fill_rdy1", 32'(wr_ready[1]), 32'((k + 1) <= 6));
    end
    // Write and read together on a full channel
`ifdef FIFO_BANK_MERGE_FWFT_EN
    check_eq("sim_head", dout(1), 32'h11);
`endif
    set_word(1, 8'h21); next_stg_rd_en = 1'b1; en_intake = 4'b0010;
    tick();
    next_stg_rd_en = 1'b0; en_intake = '0;
    check_eq("sim_occ1", occ(1), 8);
    check_eq("sim_ovf1", 32'(overflow[1]), 0);
`ifndef FIFO_BANK_MERGE_FWFT_EN
    check_eq("sim_dout1", dout(1), 32'h11);
    check_eq("sim_vld1", 32'(data_out_valid[1]), 1);
`endif
    // Overflow: dropped write
    set_word(1, 8'h23);
    tick();
    blk_en_adv = '0;
    check_eq("ovf_occ1", occ(1), 8);
    check_eq("ovf_flag1", 32'(overflow), 32'h2);
    tick();
    check_eq("ovf_sticky1", 32'(overflow[1]), 1);
    for (int k = 1; k < 8; k++) read_one(1, 8'(8'h11 + 2 * k), "drain1");
    read_one(1, 8'h21, "drain1_last");
    check_eq("drain_occ1", occ(1), 0);
    check_eq("drain_ovf1", 32'(overflow[1]), 1);

    // Flush with partially filled ch0 and ch2
    set_word(0, 8'hD1); set_word(2, 8'hE1); blk_en_adv = 4'b0101;
    tick();
    set_word(0, 8'hD3); blk_en_adv = 4'b0001;
    tick();
    blk_en_adv = '0;
    check_eq("pre_fl_occ0", occ(0), 2);
    check_eq("pre_fl_occ2", occ(2), 1);
    flush = 1'b1; blk_en_adv = 4'b0101; next_stg_rd_en = 1'b1; en_intake = 4'b0001;
    tick();
    flush = 1'b0; blk_en_adv = '0; next_stg_rd_en = 1'b0; en_intake = '0;
    check_eq("fl_occ", 32'(occupancy), 0);
    check_eq("fl_empty", 32'(fifo_empty), 32'hF);
    check_eq("fl_ovf", 32'(overflow), 0);
    check_eq("fl_vld", 32'(data_out_valid), 0);
    check_eq("fl_dout0", dout(0), 32'hC5);
    set_word(2, 8'hF1); blk_en_adv = 4'b0100;
    tick();
    blk_en_adv = '0;
    check_eq("postfl_occ2", occ(2), 1);
    read_one(2, 8'hF1, "postfl_rd2");

    // Asynchronous reset mid-burst
    set_word(0, 8'h71); blk_en_adv = 4'b0001;
    tick(); tick();
    check_eq("burst_occ0", occ(0), 2);
    #2 rst_b = 1'b0;
    #1;
    check_eq("arst_occ", 32'(occupancy), 0);
    check_eq("arst_empty", 32'(fifo_empty), 32'hF);
    check_eq("arst_dout", 32'(data_out), 0);
    check_eq("arst_vld", 32'(data_out_valid), 0);
    check_eq("arst_rdy", 32'(wr_ready), 0);
    blk_en_adv = '0;
    tick();
    rst_b = 1'b1;
    tick();
    check_eq("postrst_occ0", occ(0), 0);

    // Single write of 0x5F on ch3, no read, then pop
    set_word(3, 8'h5F); blk_en_adv = 4'b1000;
    tick();
    blk_en_adv = '0;
`ifdef FIFO_BANK_MERGE_FWFT_EN
    check_eq("fwft_dout3", dout(3), 32'h5F);
    check_eq("fwft_vld3", 32'(data_out_valid[3]), 1);
    tick();
    check_eq("fwft_hold3", dout(3), 32'h5F);
`else
    check_eq("nord_vld3", 32'(data_out_valid[3]), 0);
    tick();
`endif
    read_one(3, 8'h5F, "pop3");
    tick();
    check_eq("pop3_vld", 32'(data_out_valid[3]), 0);
    check_eq("pop3_empty", 32'(fifo_empty[3]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fifo_bank_merge_sync.md
Name: fifo_bank_merge_sync

Overview:
- Parametrised bank of NUM_CH independent synchronous FIFOs between one merge stage and the next, all on a single clock domain.
- Per channel: strips the add-stage payload from the upstream segment word and filters on the valid bit. Writes are gated by mode/unit enable.
- Gives a registered write-ready with a configurable safety margin. Reads are driven by the downstream intake enables.
- Adds over the slow/fast async bank: occupancy counts, sticky overflow flags, synchronous flush, and an optional first-word-fall-through output.

Parameters:
- DATA_WIDTH, `DATA_WIDTH_BUFF_SO_SEG, width of the upstream segment word.
- DATA_WIDTH_ADD_STG, `DATA_WIDTH_ADD_STG, stored payload width (top bits of the segment word); bit 0 is the valid bit.
- NUM_CH, `NUM_SEG_PER_STG, number of channels.
- BITS_ADDR, `BITS_SLOW_BLK_BUFF_ADDR, address bits per FIFO; DEPTH = 2**BITS_ADDR.
- READY_MARGIN, 2, free entries to keep in reserve before deasserting ready (covers the registered-ready lag); legal range 1..DEPTH-1.

Ports:
- clk  input  1  clock.
- rst_b  input  1  asynchronous active-low reset.
- unit_en  input  1  unit enable.
- mode  input  1  `MODE_WORK enables writes and ready.
- flush  input  1  synchronous clear of all channels.
- next_stg_rd_en  input  1  global read permit from the downstream stage.
- blk_en_adv  input  NUM_CH  per-channel upstream advance strobe.
- data_in_blk  input  NUM_CH x DATA_WIDTH  upstream segment words.
- en_intake  input  NUM_CH  downstream per-channel intake request.
- data_out  output  NUM_CH x DATA_WIDTH_ADD_STG  read data.
- data_out_valid  output  NUM_CH  read data qualifier.
- fifo_empty  output  NUM_CH  channel empty.
- wr_ready_adv  output  NUM_CH  combinational ready.
- wr_ready  output  NUM_CH  wr_ready_adv registered one cycle.
- occupancy  output  NUM_CH x (BITS_ADDR+1)  entries held.
- overflow  output  NUM_CH  sticky write-while-full flag.

Behaviour:
- Reset (async, rst_b=0): pointers, occupancy, overflow, data_out, data_out_valid and wr_ready all go to 0; fifo_empty goes to all-ones. Reset mid-operation discards contents; no partial state survives.
- Payload: din[i] = data_in_blk[i][DATA_WIDTH-1 : DATA_WIDTH-DATA_WIDTH_ADD_STG].
- Write request: wreq[i] = (mode==`MODE_WORK) & unit_en & blk_en_adv[i] & din[i][0]. Invalid words are never stored.
- Write accept: wreq[i] & (!full[i] | rd[i]). A write to a full channel is accepted when a read happens in the same cycle.
- Overflow: wreq[i] while full[i] with no read drops the data and sets overflow[i]. overflow[i] clears only on reset or flush.
- Read: rd[i] = next_stg_rd_en & en_intake[i] & !fifo_empty[i]. An empty channel ignores read requests; write+read on an empty channel stores the word and pops nothing.
- Pointers: BITS_ADDR+1 bits each; wrap is natural modulo 2*DEPTH.
  - full = (MSBs differ) & (low bits equal).
  - empty = pointers equal.
- Occupancy: +1 on accepted write only, -1 on read only, unchanged when both occur.
- Ready:
  - wr_ready_adv[i] = (mode==`MODE_WORK) & (occupancy[i] <= DEPTH-1-READY_MARGIN).
  - wr_ready is wr_ready_adv delayed one cycle.
  - With mode not `MODE_WORK, both readies are 0.
- Read data (default): data_out[i] is registered and loaded on rd[i]. data_out_valid[i] pulses high for exactly the cycle after rd[i]. data_out holds its value when there is no read.
- Flush: on the next edge, pointers, occupancy and overflow go to 0 and data_out_valid goes to 0. Writes and reads in the flush cycle are ignored. data_out keeps its last value.
- Channels are fully independent; one channel's events never affect another.

Optional Feature:
- Macro FIFO_BANK_MERGE_FWFT_EN.
- Defined: first-word-fall-through. data_out[i] always shows the head entry and data_out_valid[i] = !fifo_empty[i]. rd[i] pops the head, so the next entry is visible on the following cycle with zero extra latency. Flush and reset behave as without the macro.
- Undefined: registered one-cycle read behaviour as above.

Test Plan:
- Reset, then 3 writes of valid words 0xA1, 0xB3, 0xC5 (bit 0 set) on ch0, then 3 reads → occupancy goes 1,2,3; data_out 0xA1, 0xB3, 0xC5 each one cycle after rd, with data_out_valid pulses; fifo_empty[0]=1 afterwards.
- Write with din bit 0 = 0, and writes with mode not `MODE_WORK or unit_en=0 → occupancy stays 0 and fifo_empty stays 1.
- DEPTH=8, READY_MARGIN=2: fill ch1 → wr_ready_adv falls when occupancy=6 and wr_ready falls one cycle later. Write 9th word while full → dropped, overflow[1]=1, occupancy=8.
- Full channel with simultaneous write and read → both accepted, occupancy stays 8, overflow stays 0. Empty channel with read request → no pop, no data_out_valid.
- Partially filled ch0 and ch2: assert flush → next cycle occupancy=0, empty=1, overflow=0 on all channels. Assert rst_b low mid-burst → all outputs at reset values immediately.
- FIFO_BANK_MERGE_FWFT_EN defined: after a single write of 0x5F → data_out=0x5F with data_out_valid=1 the next cycle with no read. rd pops it and data_out_valid drops.
